// File: rtl/inverter_test_ctrl.sv
// inverter_test_ctrl
//   Sequencer for the analog inverter macro. Drives the inverter input through
//   a programmed number of full pulses (two edges each). It brings the inverter
//   output back into the clk domain, then times each edge in clk cycles. Edges
//   that are answered before TIMEOUT are counted as passes. Edges that are not
//   answered in time are counted as fails.
//
//   Ports:
//     clk        tile clock
//     rst_n      asynchronous active-low reset
//     ena        tile enable; low aborts any run (no done pulse)
//     start      single-cycle run request, honoured only in IDLE with ena high
//     n_pulses   full pulses per run, sampled on an accepted start
//     inv_out    inverter output, asynchronous to clk
//     inv_in     registered drive to the inverter input
//     busy       high in every state except IDLE
//     done       one-cycle pulse when a run completes normally
//     pass_cnt   edges answered within TIMEOUT (saturating)
//     fail_cnt   edges that timed out (saturating)
//     last_delay wait_cnt value captured at the most recent passing edge
//
//   The FSM state register is the signal "state" (type state_t).
module inverter_test_ctrl #(
   parameter int TIMEOUT     = 64,  // 4..255
   parameter int SYNC_STAGES = 2    // 2..4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       start,
   input  logic [7:0] n_pulses,
   input  logic       inv_out,
   output logic       inv_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] pass_cnt,
   output logic [7:0] fail_cnt,
   output logic [7:0] last_delay
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRIVE = 3'd1,
      WAIT  = 3'd2,
      NEXT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   out_s;
   logic                   level;     // inv_in value the current edge drives
   logic [7:0]             n_lat;
   logic [7:0]             wait_cnt;
   logic [8:0]             edge_cnt;

   logic accept;
   logic respond;
   logic timed_out;
   logic last_edge;
   logic abort;

   // Synchroniser for the asynchronous inverter output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], inv_out};
      end
   end
   assign out_s = sync_q[SYNC_STAGES-1];

   assign accept    = (state == IDLE) && start && ena;
   // A healthy inverter answers with the complement of the driven level.
   assign respond   = (out_s != level);
   assign timed_out = (wait_cnt == TMO_LAST);
   assign last_edge = ((edge_cnt + 9'd1) == {n_lat, 1'b0});
   assign abort     = !ena && (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = (n_pulses != 8'd0) ? DRIVE : DONE;
            end
         end
         DRIVE: state_nxt = WAIT;
         WAIT: begin
            if (respond || timed_out) begin
               state_nxt = NEXT;
            end
         end
         NEXT:    state_nxt = last_edge ? DONE : DRIVE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // Dropping ena wins over everything and skips the done pulse.
      if (abort) begin
         state_nxt = IDLE;
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inv_in     <= 1'b0;
         level      <= 1'b0;
         n_lat      <= '0;
         wait_cnt   <= '0;
         edge_cnt   <= '0;
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         last_delay <= '0;
      end else if (abort) begin
         // Partial results stay visible; only the drive is parked low.
         inv_in <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               inv_in <= 1'b0;
               if (accept) begin
                  n_lat      <= n_pulses;
                  pass_cnt   <= '0;
                  fail_cnt   <= '0;
                  last_delay <= '0;
                  edge_cnt   <= '0;
                  wait_cnt   <= '0;
                  level      <= 1'b1;
               end
            end
            DRIVE: begin
               inv_in   <= level;
               wait_cnt <= '0;
            end
            WAIT: begin
               // A response in the timeout cycle still counts as a pass.
               if (respond) begin
                  if (pass_cnt != 8'hFF) begin
                     pass_cnt <= pass_cnt + 8'd1;
                  end
                  last_delay <= wait_cnt;
               end else if (timed_out) begin
                  if (fail_cnt != 8'hFF) begin
                     fail_cnt <= fail_cnt + 8'd1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            NEXT: begin
               level    <= ~level;
               edge_cnt <= edge_cnt + 9'd1;
            end
            DONE: begin
               inv_in <= 1'b0;
            end
            default: begin
               inv_in <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inverter_test_ctrl.sv
// Testbench for inverter_test_ctrl: inverter behaviour models, directed vector
// table, hand-written multi-cycle corner sequences and randomized runs
// checked against an edge-level reference model.
module tb_inverter_test_ctrl;

   localparam int TO = 64;
   localparam int SS = 2;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       start = 1'b0;
   logic [7:0] n_pulses = 8'd0;
   logic       inv_out;
   logic       inv_in;
   logic       busy;
   logic       done;
   logic [7:0] pass_cnt;
   logic [7:0] fail_cnt;
   logic [7:0] last_delay;

   always #5 clk = ~clk;

   inverter_test_ctrl #(.TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .start      (start),
      .n_pulses   (n_pulses),
      .inv_out    (inv_out),
      .inv_in     (inv_in),
      .busy       (busy),
      .done       (done),
      .pass_cnt   (pass_cnt),
      .fail_cnt   (fail_cnt),
      .last_delay (last_delay)
   );

   // ---------------- inverter models ----------------
   // mode 0: ideal, 1: delayed by model_delay clk cycles, 2: stuck 1, 3: stuck 0
   int          mode = 0;
   int          model_delay = 1;
   logic [15:0] dly;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) dly <= '1;
      else        dly <= {dly[14:0], ~inv_in};
   end

   always_comb begin
      case (mode)
         0:       inv_out = ~inv_in;
         1:       inv_out = dly[4'(model_delay - 1)];
         2:       inv_out = 1'b1;
         default: inv_out = 1'b0;
      endcase
   end

   // ---------------- scoreboard ----------------
   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Edge-level reference: each edge either answers after a known latency or
   // never answers; its cost in cycles follows from that.
   task automatic model(input int m, input int d, input int n,
                        output int p, output int f, output int last, output int cyc);
      p = 0; f = 0; last = 0; cyc = 0;
      for (int e = 0; e < 2 * n; e++) begin
         bit lvl_high;
         bit ok;
         int r;
         lvl_high = (e % 2 == 0);
         case (m)
            0:       begin ok = 1'b1;      r = SS;     end
            1:       begin ok = 1'b1;      r = SS + d; end
            2:       begin ok = !lvl_high; r = 0;      end
            default: begin ok = lvl_high;  r = 0;      end
         endcase
         if (ok && r <= TO - 1) begin
            p    = (p < 255) ? p + 1 : 255;
            last = r;
            cyc  += r + 3;
         end else begin
            f    = (f < 255) ? f + 1 : 255;
            cyc  += TO + 2;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) @(negedge clk);
   endtask

   // Runs one start-to-done sequence and checks results. poke_at >= 0 issues an
   // extra start (with a different n_pulses) at that cycle of the run.
   task automatic apply(input string tag, input int m, input int d, input int n,
                        input int poke_at, input int ep, input int ef,
                        input int el, input int eb);
      int busy_cycles;
      int saw_high;
      bit expired;
      mode = m;
      model_delay = d;
      idle(20);
      start = 1'b1;
      n_pulses = 8'(n);
      @(negedge clk);
      start = 1'b0;
      busy_cycles = 0;
      saw_high = 0;
      expired = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         if (inv_in) saw_high = 1;
         if (done) begin
            expired = 1'b0;
            break;
         end
         if (busy) busy_cycles++;
         if (i == poke_at) begin
            start = 1'b1;
            n_pulses = 8'd50;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, "_done_seen"}, int'(expired), 0);
      check({tag, "_pass_cnt"}, int'(pass_cnt), ep);
      check({tag, "_fail_cnt"}, int'(fail_cnt), ef);
      check({tag, "_last_delay"}, int'(last_delay), el);
      check({tag, "_busy_cycles"}, busy_cycles, eb);
      check({tag, "_inv_in_rose"}, saw_high, int'(n != 0));
      @(negedge clk);
      check({tag, "_done_once"}, int'(done), 0);
      check({tag, "_idle_after"}, int'(busy), 0);
      check({tag, "_inv_in_low"}, int'(inv_in), 0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      string tag;
      int    m;
      int    d;
      int    n;
      int    poke;
      int    ep;
      int    ef;
      int    el;
      int    eb;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int p, f, l, c;
      bit reached;

      vecs[0] = '{"ideal_n3",    0, 1, 3,   -1, 6,   0, 2, 30};
      vecs[1] = '{"delay5_n1",   1, 5, 1,   -1, 2,   0, 7, 20};
      vecs[2] = '{"stuck1_n2",   2, 1, 2,   -1, 2,   2, 0, 138};
      vecs[3] = '{"zero_pulses", 0, 1, 0,   -1, 0,   0, 0, 0};
      vecs[4] = '{"stuck0_n1",   3, 1, 1,   -1, 1,   1, 0, 69};
      vecs[5] = '{"start_busy",  0, 1, 2,    7, 4,   0, 2, 20};
      vecs[6] = '{"saturate",    0, 1, 200, -1, 255, 0, 2, 2000};

      // reset state
      idle(3);
      check("rst_inv_in", int'(inv_in), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_pass", int'(pass_cnt), 0);
      check("rst_fail", int'(fail_cnt), 0);
      check("rst_last", int'(last_delay), 0);
      rst_n = 1'b1;
      idle(2);

      // start with ena low is ignored
      start = 1'b1;
      n_pulses = 8'd3;
      @(negedge clk);
      start = 1'b0;
      check("start_no_ena_busy", int'(busy), 0);
      ena = 1'b1;

      for (int i = 0; i < 7; i++) begin
         apply(vecs[i].tag, vecs[i].m, vecs[i].d, vecs[i].n, vecs[i].poke,
               vecs[i].ep, vecs[i].ef, vecs[i].el, vecs[i].eb);
      end

      // drop ena two edges into a 4-pulse run
      mode = 0;
      idle(20);
      start = 1'b1;
      n_pulses = 8'd4;
      @(negedge clk);
      start = 1'b0;
      reached = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (pass_cnt == 8'd2) begin
            reached = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("ena_drop_reached", int'(reached), 1);
      ena = 1'b0;
      @(negedge clk);
      check("ena_drop_busy", int'(busy), 0);
      check("ena_drop_inv_in", int'(inv_in), 0);
      check("ena_drop_pass", int'(pass_cnt), 2);
      check("ena_drop_fail", int'(fail_cnt), 0);
      p = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) p++;
         @(negedge clk);
      end
      check("ena_drop_no_done", p, 0);
      check("ena_drop_hold", int'(pass_cnt), 2);
      ena = 1'b1;

      // asynchronous reset in the middle of a WAIT
      mode = 2;
      idle(20);
      start = 1'b1;
      n_pulses = 8'd2;
      @(negedge clk);
      start = 1'b0;
      idle(80);
      check("pre_rst_inv_in", int'(inv_in), 1);
      check("pre_rst_pass", int'(pass_cnt), 1);
      check("pre_rst_fail", int'(fail_cnt), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_inv_in", int'(inv_in), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_pass", int'(pass_cnt), 0);
      check("mid_rst_fail", int'(fail_cnt), 0);
      check("mid_rst_last", int'(last_delay), 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // randomized runs against the reference model
      for (int i = 0; i < 14; i++) begin
         int m, d, n;
         m = int'($urandom_range(0, 3));
         d = int'($urandom_range(1, 12));
         n = int'($urandom_range(0, 6));
         model(m, d, n, p, f, l, c);
         apply($sformatf("rand%0d_m%0d_d%0d_n%0d", i, m, d, n), m, d, n, -1, p, f, l, c);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/inverter_test_ctrl.md
Name: inverter_test_ctrl

Overview:
- Digital sequencer that exercises the analog inverter macro in a Tiny Tapeout tile.
- Drives the inverter input through a programmed number of full pulses and synchronises the inverter output back into the clock domain.
- Measures the response delay of each edge in clock cycles, and counts passing and timed-out edges.
- Sits beside the analog macro in the tile top level. Results are exported on dedicated outputs.

Parameters:
- TIMEOUT, 64, cycles waited per edge before declaring a fail; legal range 4..255.
- SYNC_STAGES, 2, flops in the inv_out synchroniser; legal range 2..4.

Ports:
- clk  input  1  tile clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  tile enable; low aborts any run
- start  input  1  single-cycle run request
- n_pulses  input  8  full pulses per run (2 edges each); sampled on an accepted start
- inv_out  input  1  inverter output, asynchronous to clk
- inv_in  output  1  registered drive to the inverter input
- busy  output  1  high while a run is active
- done  output  1  one-cycle pulse when a run completes normally
- pass_cnt  output  8  edges answered within TIMEOUT; saturates at 255
- fail_cnt  output  8  edges that timed out; saturates at 255
- last_delay  output  8  wait_cnt value captured at the last passing edge

Behaviour:
- Reset (async, rst_n low): state IDLE, inv_in=0, busy=0, done=0, pass_cnt=0, fail_cnt=0, last_delay=0. Synchroniser flops and internal counters are cleared.
- Synchroniser: inv_out passes through SYNC_STAGES flops to give out_s. The controller never uses raw inv_out.
- States: IDLE, DRIVE, WAIT, NEXT, DONE. busy=1 in every state except IDLE.
- IDLE:
  - inv_in=0.
  - start=1 and ena=1 with n_pulses!=0: latch n_pulses, clear pass_cnt, fail_cnt, last_delay and edge_cnt, set level=1, go to DRIVE.
  - start with n_pulses=0: go straight to DONE with counters cleared.
  - start with ena=0: ignored.
- DRIVE (1 cycle): inv_in<=level, wait_cnt<=0, go to WAIT.
- WAIT: evaluated each cycle in this priority order:
  - out_s == ~level: pass_cnt+=1 (saturating), last_delay<=wait_cnt, go to NEXT.
  - else wait_cnt == TIMEOUT-1: fail_cnt+=1 (saturating), go to NEXT.
  - else wait_cnt+=1.
  - A response arriving in the same cycle as the timeout counts as a pass.
- NEXT (1 cycle): level<=~level, edge_cnt+=1. If edge_cnt+1 == 2*n_pulses go to DONE, else go to DRIVE. edge_cnt is 9 bits wide.
- DONE (1 cycle): done=1, inv_in<=0, go to IDLE. Results hold until the next accepted start.
- Edge order: the first edge of every run drives inv_in high. Idle inv_in=0 means out_s is already 1, so there are no stale passes. Edges then alternate high/low and the run ends with inv_in low.
- Ideal inverter (zero delay): each edge passes with last_delay = SYNC_STAGES.
  - Cycle of DRIVE's edge: inv_in updates.
  - WAIT cycles 0..SYNC_STAGES-1: out_s not yet updated.
  - Detection occurs at wait_cnt = SYNC_STAGES.
- Edge timing: each passing edge takes 1 (DRIVE) + (delay+1) (WAIT) + 1 (NEXT) cycles. Each failing edge takes TIMEOUT+2 cycles.
- start while busy: ignored, with no effect on the run or counters.
- ena low in any non-IDLE state:
  - Next cycle: state IDLE, inv_in=0, busy=0, no done pulse.
  - pass_cnt, fail_cnt and last_delay keep their partial values.
- Reset mid-run: immediate return to reset values, including inv_in=0.

Test Plan:
- Ideal model (inv_out = ~inv_in combinationally), n_pulses=3, defaults -> pass_cnt=6, fail_cnt=0, last_delay=2. done pulses exactly once, busy high for 6*5=30 cycles.
- Model delayed by 5 clk cycles, n_pulses=1 -> pass_cnt=2, last_delay=7.
- inv_out stuck at 1, n_pulses=2, TIMEOUT=64 -> first edge fails, second edge passes at once with last_delay=0. Third edge fails, fourth passes. Final pass_cnt=2, fail_cnt=2.
- n_pulses=0 -> done one cycle after start, counters 0, inv_in never rises.
- Drop ena two edges into an n_pulses=4 run -> IDLE next cycle, inv_in=0, no done, pass_cnt=2. A second start during the run is ignored.
- Assert rst_n low mid-WAIT -> all outputs return to 0 asynchronously. n_pulses=200 with ideal model -> pass_cnt saturates at 255, fail_cnt=0.
